// File: rtl/char_term_buffer.sv
// Character terminal buffer: cursor placement, CR/LF/BS/TAB/FF handling, auto-wrap, 1-cycle read port.
// Define CHAR_TERM_SCROLL_EN to scroll at the bottom line; otherwise the screen freezes once full.
module char_term_buffer #(
   parameter int         COLS  = 86,
   parameter int         ROWS  = 32,
   parameter int         TABW  = 8,
   parameter logic [7:0] BLANK = 8'h20,
   localparam int        CW    = $clog2(COLS),
   localparam int        RW    = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wreq,
   input  logic [7:0]    wchar,
   output logic          wready,
   input  logic [CW-1:0] rx,
   input  logic [RW-1:0] ry,
   output logic [7:0]    rdata,
   output logic [CW-1:0] cur_x,
   output logic [RW-1:0] cur_y
);

   localparam int AW = RW + CW;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CLR_ROW = 2'd1;
   localparam logic [1:0] S_CLR_ALL = 2'd2;

   localparam logic [CW-1:0] X_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] Y_LAST = RW'(ROWS - 1);

   localparam logic [7:0] CH_BS  = 8'd8;
   localparam logic [7:0] CH_TAB = 8'd9;
   localparam logic [7:0] CH_LF  = 8'd10;
   localparam logic [7:0] CH_FF  = 8'd12;
   localparam logic [7:0] CH_CR  = 8'd13;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] x_q, x_d;
   logic [RW-1:0] y_q, y_d;
   logic [RW-1:0] top_q, top_d;
   logic [CW-1:0] clr_col_q, clr_col_d;
   logic [RW-1:0] clr_row_q, clr_row_d;
   logic          last_cr_q, last_cr_d;
   logic          full_q, full_d;
   logic [7:0]    rdata_q;

   logic          we;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;
   logic [AW-1:0] raddr;
   logic          newline;
   logic [CW:0]   tab_sum;
   logic [CW-1:0] tab_x;

   logic [7:0] mem [0:(2**AW)-1];

   // Logical row to physical row through the circular top offset.
   function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] row, input logic [RW-1:0] top);
      logic [RW:0] sum;
      sum = {1'b0, row} + {1'b0, top};
      if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
      return sum[RW-1:0];
   endfunction

   always_comb begin
      tab_sum = ({1'b0, x_q} | (CW+1)'(TABW - 1)) + (CW+1)'(1);
      tab_x   = (tab_sum > (CW+1)'(COLS - 1)) ? X_LAST : tab_sum[CW-1:0];
   end

   assign raddr = {phys_row(ry, top_q), rx};

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves a latch behind.
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      top_d     = top_q;
      clr_col_d = clr_col_q;
      clr_row_d = clr_row_q;
      last_cr_d = last_cr_q;
      full_d    = full_q;
      we        = 1'b0;
      waddr     = {phys_row(y_q, top_q), x_q};
      wdata     = BLANK;
      newline   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (wreq) begin
               if (wchar == CH_FF) begin
                  x_d       = '0;
                  y_d       = '0;
                  top_d     = '0;
                  full_d    = 1'b0;
                  last_cr_d = 1'b0;
                  clr_row_d = '0;
                  clr_col_d = '0;
                  state_d   = S_CLR_ALL;
               end else if (!full_q) begin
                  last_cr_d = 1'b0;
                  case (wchar)
                     CH_CR: begin
                        x_d       = '0;
                        newline   = 1'b1;
                        last_cr_d = 1'b1;
                     end
                     CH_LF: begin
                        if (!last_cr_q) begin
                           x_d     = '0;
                           newline = 1'b1;
                        end
                     end
                     CH_BS: begin
                        if (x_q != '0) x_d = x_q - CW'(1);
                     end
                     CH_TAB: x_d = tab_x;
                     default: begin
                        we    = 1'b1;
                        wdata = wchar;
                        if (x_q != X_LAST) begin
                           x_d = x_q + CW'(1);
                        end else begin
                           x_d     = '0;
                           newline = 1'b1;
                        end
                     end
                  endcase

                  if (newline) begin
                     if (y_q != Y_LAST) begin
                        y_d = y_q + RW'(1);
                     end else begin
`ifdef CHAR_TERM_SCROLL_EN
                        // The old top row becomes the new bottom line and must be blanked.
                        top_d     = (top_q == Y_LAST) ? '0 : top_q + RW'(1);
                        clr_row_d = top_q;
                        clr_col_d = '0;
                        state_d   = S_CLR_ROW;
`else
                        full_d = 1'b1;
`endif
                     end
                  end
               end
            end
         end

         S_CLR_ROW: begin
            we    = 1'b1;
            waddr = {clr_row_q, clr_col_q};
            if (clr_col_q == X_LAST) begin
               clr_col_d = '0;
               state_d   = S_IDLE;
            end else begin
               clr_col_d = clr_col_q + CW'(1);
            end
         end

         S_CLR_ALL: begin
            we    = 1'b1;
            waddr = {clr_row_q, clr_col_q};
            if (clr_col_q == X_LAST) begin
               clr_col_d = '0;
               if (clr_row_q == Y_LAST) begin
                  clr_row_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  clr_row_d = clr_row_q + RW'(1);
               end
            end else begin
               clr_col_d = clr_col_q + CW'(1);
            end
         end

         default: state_d = S_CLR_ALL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLR_ALL;
         x_q       <= '0;
         y_q       <= '0;
         top_q     <= '0;
         clr_col_q <= '0;
         clr_row_q <= '0;
         last_cr_q <= 1'b0;
         full_q    <= 1'b0;
         rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking here, so the read below sees the top and cell contents from before this edge.
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         top_q     <= top_d;
         clr_col_q <= clr_col_d;
         clr_row_q <= clr_row_d;
         last_cr_q <= last_cr_d;
         full_q    <= full_d;
         rdata_q   <= mem[raddr];
      end
   end

   // NOTE: the array has no reset; reset starts CLR_ALL, which blanks it cell by cell instead.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign wready = (state_q == S_IDLE);
   assign rdata  = rdata_q;
   assign cur_x  = x_q;
   assign cur_y  = y_q;

endmodule
